// File: rtl/spio_hss_multiplexer_reg_access_if.sv
// Request, response and register-bank port bundle for the spiNNlink
// register-access initiator. The initiator uses the slave view; whoever
// issues commands and hosts the register bank uses the master view.
interface spio_hss_multiplexer_reg_access_if #(
    parameter int REGA_BITS = 5,
    parameter int REGD_BITS = 32,
    parameter int LEN_BITS  = 4
) ();

    // command channel
    logic                 req_vld;
    logic                 req_rdy;
    logic                 req_write;
    logic [REGA_BITS-1:0] req_addr;
    logic [REGD_BITS-1:0] req_data;
    logic [LEN_BITS-1:0]  req_len;

    // response channel
    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic [REGD_BITS-1:0] rsp_data;
    logic                 rsp_last;

    // register bank port
    logic                 reg_write;
    logic [REGA_BITS-1:0] reg_addr;
    logic [REGD_BITS-1:0] reg_write_data;
    logic [REGD_BITS-1:0] reg_read_data;

    modport slave (
        input  req_vld, req_write, req_addr, req_data, req_len,
        output req_rdy,
        output rsp_vld, rsp_data, rsp_last,
        input  rsp_rdy,
        output reg_write, reg_addr, reg_write_data,
        input  reg_read_data
    );

    modport master (
        output req_vld, req_write, req_addr, req_data, req_len,
        input  req_rdy,
        input  rsp_vld, rsp_data, rsp_last,
        output rsp_rdy,
        input  reg_write, reg_addr, reg_write_data,
        output reg_read_data
    );

endinterface

// File: rtl/spio_hss_multiplexer_reg_access.sv
// Register-access initiator for the spiNNlink register bank.
// Takes one read/write command at a time. A write produces a single-cycle
// bank write strobe followed by one ack beat echoing the data. A read of
// req_len+1 consecutive registers produces one beat per register. The bank
// registers its read data, so each read beat waits one cycle (RWAIT) after
// the address is stable before capturing (RCAPT). reg_addr stays fixed from
// issue to capture so the captured data always belongs to that address.
module spio_hss_multiplexer_reg_access #(
    parameter int REGA_BITS = 5,
    parameter int REGD_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic clk,
    input  logic rst,
    spio_hss_multiplexer_reg_access_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WACK,
        RWAIT,
        RCAPT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 req_rdy_q, req_rdy_d;
    logic                 rsp_vld_q, rsp_vld_d;
    logic                 rsp_last_q, rsp_last_d;
    logic [REGD_BITS-1:0] rsp_data_q, rsp_data_d;
    logic                 reg_write_q, reg_write_d;
    logic [REGA_BITS-1:0] reg_addr_q, reg_addr_d;
    logic [REGD_BITS-1:0] reg_wdata_q, reg_wdata_d;
    logic [LEN_BITS-1:0]  remaining_q, remaining_d;

    // State register and all registered outputs; reset aborts any command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_rdy_q   <= 1'b1;
            rsp_vld_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            req_rdy_q   <= req_rdy_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state and next-output logic; the write strobe defaults low so it
    // can only ever be a single-cycle pulse on entry to WACK.
    always_comb begin
        state_d     = state_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;
        reg_write_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        remaining_d = remaining_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_vld) begin
                    reg_addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        reg_wdata_d = bus.req_data;
                        reg_write_d = 1'b1;
                        state_d     = WACK;
                    end else begin
                        remaining_d = bus.req_len;
                        state_d     = RWAIT;
                    end
                end
            end
            WACK: begin
                rsp_data_d = reg_wdata_q;
                rsp_last_d = 1'b1;
                rsp_vld_d  = 1'b1;
                state_d    = RESP;
            end
            RWAIT: begin
                state_d = RCAPT;
            end
            RCAPT: begin
                rsp_data_d = bus.reg_read_data;
                rsp_last_d = (remaining_q == '0);
                rsp_vld_d  = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        reg_addr_d  = reg_addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d     = RWAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is registered too, so it is derived from where the FSM is going.
    always_comb begin
        req_rdy_d = (state_d == IDLE);
    end

    assign bus.req_rdy        = req_rdy_q;
    assign bus.rsp_vld        = rsp_vld_q;
    assign bus.rsp_last       = rsp_last_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.reg_write      = reg_write_q;
    assign bus.reg_addr       = reg_addr_q;
    assign bus.reg_write_data = reg_wdata_q;

endmodule
